// File: rtl/dco_pkg.sv
// Shared constants for the DCO measurement path: FSM encodings, default sizing
// and the DCO period table used to derive expected edge counts.
package dco_pkg;

   localparam int unsigned DEF_GATE_CYCLES = 256;
   localparam int unsigned DEF_CNT_W       = 8;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   // DCO output period in clk cycles for characterised control codes
   localparam int unsigned DCO_PERIOD_CODE_01 = 8;
   localparam int unsigned DCO_PERIOD_CODE_80 = 22;

   function automatic int unsigned expected_count(input int unsigned period,
                                                  input int unsigned gate);
      return gate / period;
   endfunction

endpackage

// File: rtl/dco_sync_edge.sv
// Two-flop synchroniser for an asynchronous one-bit input plus a history flop;
// emits a single-cycle pulse for each synchronised rising edge.
module dco_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/dco_freq_meter.sv
// DCO frequency meter: counts synchronised dco_in rising edges over GATE_CYCLES
// clk cycles. Define DCO_FREQ_METER_CONTINUOUS_EN for back-to-back windows.
module dco_freq_meter
   import dco_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dco_in,
   input  logic             start,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   input  logic             count_ready,
   output logic             overflow,
   output logic             busy
);

   localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [1:0]        state;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic [CNT_W-1:0]  edge_next;
   logic              sat;
   logic              sat_next;
   logic              rise;

   dco_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (dco_in),
      .rise  (rise)
   );

   // next count folds in the current cycle's rise so the last gate cycle is counted
   always_comb begin
      edge_next = edge_cnt;
      sat_next  = sat;
      if (rise) begin
         if (edge_cnt == CNT_MAX) begin
            sat_next = 1'b1;
         end else begin
            edge_next = edge_cnt + CNT_W'(1);
         end
      end
   end

`ifdef DCO_FREQ_METER_CONTINUOUS_EN
   logic unused_handshake;
   assign unused_handshake = start ^ count_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_MEASURE;
         gate_cnt    <= GATE_LOAD;
         edge_cnt    <= '0;
         sat         <= 1'b0;
         count_out   <= '0;
         count_valid <= 1'b0;
         overflow    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= ST_MEASURE;
         busy        <= (state == ST_MEASURE);
         count_valid <= 1'b0;
         if (gate_cnt == '0) begin
            count_out   <= edge_next;
            overflow    <= sat_next;
            count_valid <= 1'b1;
            gate_cnt    <= GATE_LOAD;
            edge_cnt    <= '0;
            sat         <= 1'b0;
         end else begin
            gate_cnt <= gate_cnt - GATE_W'(1);
            edge_cnt <= edge_next;
            sat      <= sat_next;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         gate_cnt    <= '0;
         edge_cnt    <= '0;
         sat         <= 1'b0;
         count_out   <= '0;
         count_valid <= 1'b0;
         overflow    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_MEASURE;
                  busy     <= 1'b1;
                  gate_cnt <= GATE_LOAD;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end
            end
            ST_MEASURE: begin
               if (gate_cnt == '0) begin
                  state       <= ST_DONE;
                  busy        <= 1'b0;
                  count_out   <= edge_next;
                  overflow    <= sat_next;
                  count_valid <= 1'b1;
               end else begin
                  gate_cnt <= gate_cnt - GATE_W'(1);
                  edge_cnt <= edge_next;
                  sat      <= sat_next;
               end
            end
            ST_DONE: begin
               if (count_ready) begin
                  count_valid <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state       <= ST_IDLE;
               busy        <= 1'b0;
               count_valid <= 1'b0;
            end
         endcase
      end
   end
`endif

endmodule
